// File: rtl/fir_seq_ctrl_if.sv
// Signal bundle between the FIR sequencing controller and the rest of
// the core: run control, both streams, tap/data RAM ports and the MAC.
// master: the controller side; slave: the surrounding core/RAM/MAC side.
interface fir_seq_ctrl_if;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_idle;
    logic        ap_done;

    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tready;

    logic        sm_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;

    logic [3:0]  tap_A;
    logic [31:0] tap_Do;
    logic [3:0]  data_A;
    logic        data_WE;
    logic [31:0] data_Di;
    logic [31:0] data_Do;

    logic [31:0] mac_x;
    logic [31:0] mac_tap;
    logic        mac_en;
    logic        mac_first;
    logic [67:0] mac_y;

    modport master (
        input  ap_start, data_length, ss_tvalid, ss_tdata, sm_tready,
        input  tap_Do, data_Do, mac_y,
        output ap_idle, ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        output tap_A, data_A, data_WE, data_Di,
        output mac_x, mac_tap, mac_en, mac_first
    );

    modport slave (
        output ap_start, data_length, ss_tvalid, ss_tdata, sm_tready,
        output tap_Do, data_Do, mac_y,
        input  ap_idle, ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        input  tap_A, data_A, data_WE, data_Di,
        input  mac_x, mac_tap, mac_en, mac_first
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: clears the circular data RAM, accepts one
// sample per input handshake, streams NTAP tap/data pairs into the MAC
// and presents the truncated result on the output stream.
// Ports: CLK, Resetn (async, active-low), bus (fir_seq_ctrl_if.master).
module fir_seq_ctrl #(
    parameter int NTAP = 11
) (
    input  logic          CLK,
    input  logic          Resetn,
    fir_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_MAC,
        S_RES,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NTAP - 1);
    localparam logic [3:0] MAC_END  = 4'(NTAP);
    localparam logic [3:0] DEPTH    = 4'(NTAP);

    state_t      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [3:0]  wptr_q, wptr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic [3:0]  rd_addr;

    // Only the low word of the accumulator is presented.
    logic unused_mac_hi;
    assign unused_mac_hi = ^bus.mac_y[67:32];

    // Newest sample sits at wptr; older ones walk backwards with wrap.
    always_comb begin
        rd_addr = 4'd0;
        if (wptr_q >= m_q) begin
            rd_addr = wptr_q - m_q;
        end else begin
            rd_addr = wptr_q + DEPTH - m_q;
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            m_q     <= 4'd0;
            wptr_q  <= 4'd0;
            cnt_q   <= 32'd0;
            len_q   <= 32'd0;
            tdata_q <= 32'd0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    assign bus.sm_tdata = tdata_q;
    assign bus.sm_tlast = tlast_q;
    assign bus.mac_x    = bus.data_Do;
    assign bus.mac_tap  = bus.tap_Do;

    always_comb begin
        state_d       = state_q;
        m_d           = m_q;
        wptr_d        = wptr_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        bus.ap_idle   = 1'b0;
        bus.ap_done   = 1'b0;
        bus.ss_tready = 1'b0;
        bus.sm_tvalid = 1'b0;
        bus.tap_A     = 4'd0;
        bus.data_A    = 4'd0;
        bus.data_WE   = 1'b0;
        bus.data_Di   = 32'd0;
        bus.mac_en    = 1'b0;
        bus.mac_first = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                if (bus.ap_start) begin
                    cnt_d   = 32'd0;
                    wptr_d  = 4'd0;
                    m_d     = 4'd0;
                    len_d   = bus.data_length;
                    tlast_d = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.data_WE = 1'b1;
                bus.data_A  = m_q;
                if (m_q == LAST_IDX) begin
                    m_d     = 4'd0;
                    state_d = (len_q == 32'd0) ? S_DONE : S_WAIT_IN;
                end else begin
                    m_d = m_q + 4'd1;
                end
            end
            S_WAIT_IN: begin
                bus.ss_tready = 1'b1;
                bus.data_A    = wptr_q;
                bus.data_Di   = bus.ss_tdata;
                if (bus.ss_tvalid) begin
                    bus.data_WE = 1'b1;
                    m_d         = 4'd0;
                    state_d     = S_MAC;
                end
            end
            S_MAC: begin
                // Addresses lead the MAC step by one cycle (RAM latency).
                if (m_q <= LAST_IDX) begin
                    bus.tap_A  = m_q;
                    bus.data_A = rd_addr;
                end
                if (m_q != 4'd0) begin
                    bus.mac_en    = 1'b1;
                    bus.mac_first = (m_q == 4'd1);
                end
                if (m_q == MAC_END) begin
                    m_d     = 4'd0;
                    state_d = S_RES;
                end else begin
                    m_d = m_q + 4'd1;
                end
            end
            S_RES: begin
                tdata_d = bus.mac_y[31:0];
                tlast_d = (cnt_q == len_q - 32'd1);
                wptr_d  = (wptr_q == LAST_IDX) ? 4'd0 : wptr_q + 4'd1;
                cnt_d   = cnt_q + 32'd1;
                state_d = S_OUT;
            end
            S_OUT: begin
                bus.sm_tvalid = 1'b1;
                if (bus.sm_tready) begin
                    state_d = (cnt_q == len_q) ? S_DONE : S_WAIT_IN;
                end
            end
            S_DONE: begin
                bus.ap_done = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: RAM and MAC models, a convolution reference
// model and a per-cycle monitor, driven by directed runs.
module tb_fir_seq_ctrl;
    logic CLK = 1'b0;
    logic Resetn = 1'b0;

    fir_seq_ctrl_if ifc ();

    fir_seq_ctrl #(.NTAP(11)) dut (
        .CLK   (CLK),
        .Resetn(Resetn),
        .bus   (ifc)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [31:0] tap_ram [16];
    logic [31:0] data_ram [16] = '{default: 32'hDEADBEEF};
    logic [31:0] tap_q = 32'd0;
    logic [31:0] dat_q = 32'd0;
    logic [67:0] acc = 68'd0;
    logic [63:0] prod;

    assign prod = {32'b0, ifc.mac_x} * {32'b0, ifc.mac_tap};

    always @(posedge CLK) begin
        tap_q <= tap_ram[ifc.tap_A];
        dat_q <= data_ram[ifc.data_A];
        if (ifc.data_WE) data_ram[ifc.data_A] <= ifc.data_Di;
        if (ifc.mac_en) acc <= ifc.mac_first ? 68'(prod) : acc + 68'(prod);
        cyc <= cyc + 1;
    end

    assign ifc.tap_Do  = tap_q;
    assign ifc.data_Do = dat_q;
    assign ifc.mac_y   = acc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d required %0d", nm, act, req);
    endtask

    task automatic fail(input string nm, input string why);
        checks++;
        $display("FAIL %s: got %s required event", nm, why);
    endtask

    // Reference model: expected outputs are the convolution of the run's
    // input history with the taps, truncated to 32 bits.
    logic [31:0] hist [$];
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic [31:0] outs [$];
    int idx = 0;
    int cur_len = 0;

    task automatic model_push(input logic [31:0] x);
        logic [31:0] s;
        s = 32'd0;
        hist.push_front(x);
        for (int k = 0; k < 11 && k < hist.size(); k++)
            s += tap_ram[k] * hist[k];
        exp_d.push_back(s);
        exp_l.push_back(idx == cur_len - 1);
        idx++;
    endtask

    // Monitor.
    int h = -100, t0 = -100, done_exp = -100;
    int mac_cnt = 0, done_cnt = 0, ss_hs = 0, sm_hs = 0;
    bit first_wait = 0, prev_v = 0, prev_r = 0, prev_done = 0;
    logic [31:0] prev_d = 32'd0;
    logic prev_l = 1'b0;

    always @(negedge CLK) begin
        if (!Resetn) begin
            prev_v = 0;
            prev_done = 0;
            first_wait = 0;
            done_exp = -100;
        end else begin
            if (ifc.ap_start && ifc.ap_idle) begin
                t0 = cyc;
                first_wait = 1;
                if (ifc.data_length == 32'd0) done_exp = cyc + 12;
            end
            if (first_wait && ifc.ss_tready) begin
                chk("clear_cycles", 64'(cyc - t0), 64'd12);
                first_wait = 0;
            end
            if (ifc.mac_en) mac_cnt++;
            if (ifc.ss_tvalid && ifc.ss_tready) begin
                h = cyc;
                mac_cnt = 0;
                ss_hs++;
            end
            if (ifc.data_WE)
                chk("ram_we_legal",
                    64'(ifc.ss_tready ? ifc.ss_tvalid : (ifc.data_Di == 32'd0)),
                    64'd1);
            if (ifc.sm_tvalid) begin
                chk("ss_tready_in_out", 64'(ifc.ss_tready), 64'd0);
                if (!prev_v) begin
                    chk("out_latency", 64'(cyc - h), 64'd14);
                end else if (!prev_r) begin
                    chk("hold_tdata", 64'(ifc.sm_tdata), 64'(prev_d));
                    chk("hold_tlast", 64'(ifc.sm_tlast), 64'(prev_l));
                end
                if (ifc.sm_tready) begin
                    sm_hs++;
                    outs.push_back(ifc.sm_tdata);
                    chk("mac_steps", 64'(mac_cnt), 64'd11);
                    if (exp_d.size() == 0) begin
                        fail("unexpected_out", "extra output");
                    end else begin
                        chk("out_data", 64'(ifc.sm_tdata), 64'(exp_d.pop_front()));
                        chk("out_last", 64'(ifc.sm_tlast), 64'(exp_l.pop_front()));
                    end
                    if (ifc.sm_tlast) done_exp = cyc + 1;
                end
            end
            if (ifc.ap_done) begin
                done_cnt++;
                chk("done_cycle", 64'(cyc), 64'(done_exp));
            end
            if (prev_done) chk("idle_after_done", 64'(ifc.ap_idle), 64'd1);
            prev_v = ifc.sm_tvalid;
            prev_r = ifc.sm_tready;
            prev_d = ifc.sm_tdata;
            prev_l = ifc.sm_tlast;
            prev_done = ifc.ap_done;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ap_idle"}, 64'(ifc.ap_idle), 64'd1);
        chk({tag, "_ap_done"}, 64'(ifc.ap_done), 64'd0);
        chk({tag, "_ss_tready"}, 64'(ifc.ss_tready), 64'd0);
        chk({tag, "_sm_tvalid"}, 64'(ifc.sm_tvalid), 64'd0);
        chk({tag, "_sm_tdata"}, 64'(ifc.sm_tdata), 64'd0);
        chk({tag, "_sm_tlast"}, 64'(ifc.sm_tlast), 64'd0);
        chk({tag, "_tap_A"}, 64'(ifc.tap_A), 64'd0);
        chk({tag, "_data_A"}, 64'(ifc.data_A), 64'd0);
        chk({tag, "_data_WE"}, 64'(ifc.data_WE), 64'd0);
        chk({tag, "_data_Di"}, 64'(ifc.data_Di), 64'd0);
        chk({tag, "_mac_en"}, 64'(ifc.mac_en), 64'd0);
        chk({tag, "_mac_first"}, 64'(ifc.mac_first), 64'd0);
    endtask

    task automatic set_taps(input bit ramp);
        for (int i = 0; i < 16; i++)
            tap_ram[i] = (i < 11) ? (ramp ? 32'(i + 1) : 32'd1) : 32'd0;
    endtask

    task automatic start_run(input int len);
        @(negedge CLK);
        ifc.data_length = 32'(len);
        ifc.ap_start = 1'b1;
        hist.delete();
        idx = 0;
        cur_len = len;
        outs.delete();
        @(posedge CLK);
        #1 ifc.ap_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x);
        int n;
        n = 0;
        @(negedge CLK);
        ifc.ss_tvalid = 1'b1;
        ifc.ss_tdata = x;
        while (!ifc.ss_tready && n < 80) begin
            @(negedge CLK);
            n++;
        end
        if (!ifc.ss_tready) begin
            fail("send_timeout", "no ss_tready");
            ifc.ss_tvalid = 1'b0;
            return;
        end
        model_push(x);
        @(posedge CLK);
        #1 ifc.ss_tvalid = 1'b0;
        ifc.ss_tdata = 32'hBAD0BAD0;
    endtask

    // Hold sm_tready low for 5 cycles while this sample's result waits.
    task automatic bp_send(input logic [31:0] x);
        int n;
        n = 0;
        @(negedge CLK);
        while (!ifc.ss_tready && n < 80) begin
            @(negedge CLK);
            n++;
        end
        ifc.sm_tready = 1'b0;
        send(x);
        n = 0;
        @(negedge CLK);
        while (!ifc.sm_tvalid && n < 30) begin
            @(negedge CLK);
            n++;
        end
        if (!ifc.sm_tvalid) fail("bp_timeout", "no sm_tvalid");
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_ss_tready", 64'(ifc.ss_tready), 64'd0);
            chk("bp_mac_en", 64'(ifc.mac_en), 64'd0);
        end
        ifc.sm_tready = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (!ifc.ap_idle && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_idle"}, 64'(ifc.ap_idle), 64'd1);
    endtask

    task automatic impulse_run(input string nm, input int len);
        int d0;
        d0 = done_cnt;
        set_taps(1'b1);
        start_run(len);
        send(32'd1);
        for (int i = 1; i < len; i++) send(32'd0);
        wait_idle(nm);
        chk({nm, "_count"}, 64'(outs.size()), 64'(len));
        for (int k = 0; k < 11 && k < outs.size(); k++)
            chk({nm, "_lit"}, 64'(outs[k]), 64'(k + 1));
        if (len > 11 && outs.size() > 11)
            chk({nm, "_lit_tail"}, 64'(outs[11]), 64'd0);
        chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int s0, m0, d0;
        ifc.ap_start = 1'b0;
        ifc.data_length = 32'd0;
        ifc.ss_tvalid = 1'b0;
        ifc.ss_tdata = 32'd0;
        ifc.sm_tready = 1'b1;
        set_taps(1'b1);
        repeat (3) @(posedge CLK);
        #1 chk_reset("por");
        @(negedge CLK);
        Resetn = 1'b1;

        impulse_run("impulse", 12);

        set_taps(1'b0);
        start_run(25);
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) bp_send(32'(i));
            else send(32'(i));
        end
        wait_idle("wrap");
        chk("wrap_count", 64'(outs.size()), 64'd25);
        if (outs.size() == 25) begin
            chk("wrap_lit0", 64'(outs[0]), 64'd1);
            chk("wrap_lit10", 64'(outs[10]), 64'd66);
            chk("wrap_lit11", 64'(outs[11]), 64'd77);
            chk("wrap_lit24", 64'(outs[24]), 64'd220);
        end

        impulse_run("b2b", 11);

        s0 = ss_hs;
        m0 = sm_hs;
        d0 = done_cnt;
        start_run(0);
        wait_idle("len0");
        chk("len0_ss_hs", 64'(ss_hs - s0), 64'd0);
        chk("len0_sm_hs", 64'(sm_hs - m0), 64'd0);
        chk("len0_done", 64'(done_cnt - d0), 64'd1);

        set_taps(1'b1);
        start_run(12);
        send(32'd5);
        repeat (5) @(posedge CLK);
        #1 Resetn = 1'b0;
        #1 chk_reset("mid_mac");
        exp_d.delete();
        exp_l.delete();
        repeat (2) @(negedge CLK);
        Resetn = 1'b1;
        impulse_run("after_rst", 12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
